// File: rtl/branch_predict_resolve_unit_pkg.sv
// Shared encodings for the jump/branch path: instruction-type codes from the
// decoder and the funct3 branch-condition codes.
package branch_predict_resolve_unit_pkg;

    // Instruction format codes as produced by the decoder.
    typedef enum logic [2:0] {
        R_TYPE = 3'd0,
        I_TYPE = 3'd1,
        S_TYPE = 3'd2,
        B_TYPE = 3'd3,
        U_TYPE = 3'd4,
        J_TYPE = 3'd5
    } instr_type_e;

    // Branch condition codes (funct3 of B-type instructions).
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/branch_condition_eval.sv
// Combinational branch-condition evaluator: decides whether a B-type
// instruction's compare is satisfied. Undefined funct3 codes resolve not-taken.
module branch_condition_eval
    import branch_predict_resolve_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            taken
);

    // Select the compare named by funct3; default keeps the output fully defined.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = (rs1 == rs2);
            F3_BNE:  taken = (rs1 != rs2);
            F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
            F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
            F3_BLTU: taken = (rs1 <  rs2);
            F3_BGEU: taken = (rs1 >= rs2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_predict_resolve_unit.sv
// Jump/branch unit: direct-mapped BTB with 2-bit saturating counters for
// fetch-time prediction, plus execute-time resolution, mispredict detection,
// redirect generation and a saturating mispredict counter.
module branch_predict_resolve_unit
    import branch_predict_resolve_unit_pkg::*;
#(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            predict_taken,
    output logic [XLEN-1:0] predict_target,
    input  logic            resolve_valid,
    input  logic [XLEN-1:0] resolve_pc,
    input  logic [2:0]      instruction_type,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic [XLEN-1:0] resolve_target,
    input  logic            resolve_pred_taken,
    input  logic [XLEN-1:0] resolve_pred_target,
    output logic            jump_branch_enable,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     mispredict_count
);

    localparam int IDX  = $clog2(ENTRIES);
    localparam int TAGW = XLEN - IDX - 2;

    // Counter encodings: strongly not-taken .. strongly taken.
    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    function automatic logic [1:0] cnt_sat_inc(input logic [1:0] c);
        return (c == CNT_ST) ? c : c + 2'd1;
    endfunction

    function automatic logic [1:0] cnt_sat_dec(input logic [1:0] c);
        return (c == CNT_SNT) ? c : c - 2'd1;
    endfunction

    // BTB storage kept in flops so a single reset cycle clears every entry.
    logic            valid_q  [ENTRIES];
    logic            valid_d  [ENTRIES];
    logic [TAGW-1:0] tag_q    [ENTRIES];
    logic [TAGW-1:0] tag_d    [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];
    logic [XLEN-1:0] target_d [ENTRIES];
    logic [1:0]      cnt_q    [ENTRIES];
    logic [1:0]      cnt_d    [ENTRIES];

    logic            mispredict_q, mispredict_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [31:0]     mispredict_count_q, mispredict_count_d;

    logic [IDX-1:0]  fetch_idx;
    logic [TAGW-1:0] fetch_tag;
    logic            fetch_hit;
    logic [IDX-1:0]  res_idx;
    logic [TAGW-1:0] res_tag;
    logic            res_hit;
    logic            is_branch;
    logic            is_jump;
    logic            cond_taken;
    logic            taken;
    logic            upd_en;
    logic            mis_now;

    logic            wr_en;
    logic [XLEN-1:0] wr_target;
    logic [1:0]      wr_cnt;

    // Byte-offset bits of the fetch address play no part in the lookup.
    logic unused_fetch_lsbs;
    assign unused_fetch_lsbs = ^fetch_pc[1:0];

    assign fetch_idx = fetch_pc[IDX+1:2];
    assign fetch_tag = fetch_pc[XLEN-1:IDX+2];
    assign res_idx   = resolve_pc[IDX+1:2];
    assign res_tag   = resolve_pc[XLEN-1:IDX+2];

    branch_condition_eval #(
        .XLEN (XLEN)
    ) u_cond (
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .taken  (cond_taken)
    );

    // Fetch-time lookup from the current (pre-update) table contents.
    always_comb begin
        fetch_hit      = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        predict_taken  = fetch_hit && cnt_q[fetch_idx][1];
        predict_target = fetch_hit ? target_q[fetch_idx] : '0;
    end

    // Execute-time resolution of the actual direction and mispredict check.
    always_comb begin
        is_branch          = (instruction_type == B_TYPE);
        is_jump            = (instruction_type == J_TYPE);
        taken              = is_jump || (is_branch && cond_taken);
        jump_branch_enable = resolve_valid && taken;
        upd_en             = resolve_valid && (is_branch || is_jump);
        res_hit            = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
        mis_now            = upd_en &&
                             ((taken != resolve_pred_taken) ||
                              (taken && (resolve_target != resolve_pred_target)));
    end

    // Work out the single BTB entry write (if any) caused by this resolution.
    always_comb begin
        wr_en     = 1'b0;
        wr_target = target_q[res_idx];
        wr_cnt    = cnt_q[res_idx];
        if (upd_en) begin
            if (taken) begin
                wr_en     = 1'b1;
                wr_target = resolve_target;
                if (!res_hit) begin
                    // Fresh allocation: jumps start strongly taken, branches weakly.
                    wr_cnt = is_jump ? CNT_ST : CNT_WT;
                end else if (is_jump) begin
                    wr_cnt = CNT_ST;
                end else begin
                    wr_cnt = cnt_sat_inc(cnt_q[res_idx]);
                end
            end else if (res_hit) begin
                wr_en  = 1'b1;
                wr_cnt = cnt_sat_dec(cnt_q[res_idx]);
            end
        end
    end

    // Next-state for every BTB entry: only the resolved index can change.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            valid_d[i]  = valid_q[i];
            tag_d[i]    = tag_q[i];
            target_d[i] = target_q[i];
            cnt_d[i]    = cnt_q[i];
            if (wr_en && (res_idx == IDX'(i))) begin
                valid_d[i]  = 1'b1;
                tag_d[i]    = res_tag;
                target_d[i] = wr_target;
                cnt_d[i]    = wr_cnt;
            end
        end
    end

    // Next-state for the mispredict pulse, redirect address and counter.
    always_comb begin
        mispredict_d       = mis_now;
        redirect_pc_d      = redirect_pc_q;
        mispredict_count_d = mispredict_count_q;
        if (mis_now) begin
            redirect_pc_d = taken ? resolve_target : resolve_pc + XLEN'(4);
            if (mispredict_count_q != 32'hFFFF_FFFF) begin
                mispredict_count_d = mispredict_count_q + 32'd1;
            end
        end
    end

    // BTB registers; reset wins over any update resolving on the same edge.
    always_ff @(posedge clk) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (reset) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_INIT;
            end else begin
                valid_q[i]  <= valid_d[i];
                tag_q[i]    <= tag_d[i];
                target_q[i] <= target_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
        end
    end

    // Mispredict/redirect/count registers; reset discards a pending mispredict.
    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict_q       <= 1'b0;
            redirect_pc_q      <= '0;
            mispredict_count_q <= '0;
        end else begin
            mispredict_q       <= mispredict_d;
            redirect_pc_q      <= redirect_pc_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign mispredict       = mispredict_q;
    assign redirect_pc      = redirect_pc_q;
    assign mispredict_count = mispredict_count_q;

endmodule
